// File: rtl/karatsuba_mul_sequencer_if.sv
// Handshake bundle between the operand producer, the Karatsuba multiplier
// sequencer and the result consumer.
interface karatsuba_mul_sequencer_if #(
  parameter int HW = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [2*HW-1:0]   a;
  logic [2*HW-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [4*HW-1:0]   product;
  logic              busy;

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  // Multiplier side: accepts operands, presents the product.
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/karatsuba_mul_sequencer.sv
// Signed (2*HW)x(2*HW) -> 4*HW multiplier built from one HW-bit add-shift
// engine that is time-shared over the four half-width partial products.
// Magnitudes are multiplied; the sign is applied once at the end.
module karatsuba_mul_sequencer #(
  parameter int HW    = 64,
  parameter int CNT_W = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  karatsuba_mul_sequencer_if.slave   bus
);

  localparam int OW = 2 * HW;
  localparam int PW = 4 * HW;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MUL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Two's-complement magnitude; the most negative value maps to 2^(OW-1).
  function automatic logic [OW-1:0] abs_val(input logic [OW-1:0] x);
    logic [OW-1:0] r;
    if (x[OW-1]) begin
      r = ~x + OW'(1);
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Full-width two's-complement negation of the final product.
  function automatic logic [PW-1:0] neg_val(input logic [PW-1:0] x);
    return ~x + PW'(1);
  endfunction

  state_t            state_r;
  logic [1:0]        idx_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [OW-1:0]     abs_a_r;
  logic [OW-1:0]     abs_b_r;
  logic [OW-1:0]     mcand_r;
  logic [HW-1:0]     mplier_r;
  logic [OW-1:0]     partial_r;
  logic [PW-1:0]     acc_r;
  logic              sign_r;
  logic [PW-1:0]     product_r;
  logic              out_valid_r;

  logic [HW-1:0]     ld_mplier_s;
  logic [HW-1:0]     ld_mcand_s;
  logic [PW-1:0]     term_ext_s;
  logic [PW-1:0]     term_s;
  logic [PW-1:0]     acc_sum_s;

  // Operand-half selection for the pair indexed by idx: a half by idx[1], b half by idx[0].
  always_comb begin
    ld_mplier_s = abs_a_r[HW-1:0];
    ld_mcand_s  = abs_b_r[HW-1:0];
    if (idx_r[1]) begin
      ld_mplier_s = abs_a_r[OW-1:HW];
    end else begin
      ld_mplier_s = abs_a_r[HW-1:0];
    end
    if (idx_r[0]) begin
      ld_mcand_s = abs_b_r[OW-1:HW];
    end else begin
      ld_mcand_s = abs_b_r[HW-1:0];
    end
  end

  // Weight the finished partial product by its position and add it to the accumulator.
  always_comb begin
    term_ext_s = {{(PW-OW){1'b0}}, partial_r};
    term_s     = term_ext_s;
    case (idx_r)
      2'd0:    term_s = term_ext_s;
      2'd1:    term_s = term_ext_s << HW;
      2'd2:    term_s = term_ext_s << HW;
      2'd3:    term_s = term_ext_s << (2 * HW);
      default: term_s = term_ext_s;
    endcase
    acc_sum_s = acc_r + term_s;
  end

  // Sequencer: accept, load/iterate/accumulate per pair, sign the result, hold until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= 2'd0;
      cnt_r       <= {CNT_W{1'b0}};
      abs_a_r     <= {OW{1'b0}};
      abs_b_r     <= {OW{1'b0}};
      mcand_r     <= {OW{1'b0}};
      mplier_r    <= {HW{1'b0}};
      partial_r   <= {OW{1'b0}};
      acc_r       <= {PW{1'b0}};
      sign_r      <= 1'b0;
      product_r   <= {PW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            abs_a_r <= abs_val(bus.a);
            abs_b_r <= abs_val(bus.b);
            sign_r  <= bus.a[OW-1] ^ bus.b[OW-1];
            idx_r   <= 2'd0;
            acc_r   <= {PW{1'b0}};
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          mplier_r  <= ld_mplier_s;
          mcand_r   <= {{(OW-HW){1'b0}}, ld_mcand_s};
          partial_r <= {OW{1'b0}};
          cnt_r     <= CNT_W'(HW);
          state_r   <= ST_MUL;
        end
        ST_MUL: begin
          if (mplier_r[0]) begin
            partial_r <= partial_r + mcand_r;
          end else begin
            partial_r <= partial_r;
          end
          mplier_r <= mplier_r >> 1;
          mcand_r  <= mcand_r << 1;
          cnt_r    <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r <= ST_ACC;
          end else begin
            state_r <= ST_MUL;
          end
        end
        ST_ACC: begin
          acc_r <= acc_sum_s;
          if (idx_r == 2'd3) begin
            if (sign_r) begin
              product_r <= neg_val(acc_sum_s);
            end else begin
              product_r <= acc_sum_s;
            end
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            idx_r   <= idx_r + 2'd1;
            state_r <= ST_LOAD;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == ST_IDLE);
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.product   = product_r;

endmodule

// File: tb/tb_karatsuba_mul_sequencer.sv
// Self-checking bench for karatsuba_mul_sequencer: directed corner operands,
// backpressure, reset abort and randomized operands against a signed-arithmetic model.
module tb_karatsuba_mul_sequencer;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  karatsuba_mul_sequencer_if #(.HW(64)) bus ();

  karatsuba_mul_sequencer #(.HW(64), .CNT_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact signed product of sign-extended operands.
  function automatic logic [255:0] ref_mul(input logic [127:0] x, input logic [127:0] y);
    logic signed [255:0] sx;
    logic signed [255:0] sy;
    sx = {{128{x[127]}}, x};
    sy = {{128{y[127]}}, y};
    return sx * sy;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [127:0] av, input logic [127:0] bv);
    @(negedge clk);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
  endtask

  // Next edge is the accept edge; then wait for the result and check it.
  task automatic finish_op(input string tag, input logic [255:0] exp);
    int cyc;
    logic bad;
    @(posedge clk);
    #1;
    check({tag, "_accept_busy"}, {255'd0, bus.busy}, 256'd1);
    bus.in_valid = 1'b0;
    bus.a        = rand128();
    bus.b        = rand128();
    cyc = 0;
    bad = 1'b0;
    while (bus.out_valid !== 1'b1 && cyc < 400) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 256'(cyc), 256'd264);
    check({tag, "_busy_during"}, {255'd0, bad}, 256'd0);
    check({tag, "_product"}, bus.product, exp);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_idle_after"}, {254'd0, bus.out_valid, bus.in_ready}, 256'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] ra;
    logic [127:0] rb;
    logic [255:0] held;
    tests_run    = 0;
    tests_failed = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 128'd5;
    bus.b         = 128'd5;

    // Reset held with a pending operand pair: nothing captured.
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_product", bus.product, 256'd0);
    check("rst_flags", {254'd0, bus.out_valid, bus.busy}, 256'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", {254'd0, bus.in_ready, bus.busy}, 256'd2);

    // Small signed product.
    drive(128'd3, '0 - 128'd5);
    finish_op("3x-5", '0 - 256'd15);
    release_out("3x-5");

    // Most negative operand corners.
    drive(128'd1 << 127, '1);
    finish_op("min_x_m1", 256'd1 << 127);
    release_out("min_x_m1");
    drive(128'd1 << 127, 128'd1);
    finish_op("min_x_1", '0 - (256'd1 << 127));
    release_out("min_x_1");

    // Largest positive magnitudes.
    drive((128'd1 << 127) - 128'd1, (128'd1 << 127) - 128'd1);
    finish_op("maxpos_sq", (256'd1 << 254) - (256'd1 << 128) + 256'd1);
    release_out("maxpos_sq");
    drive((128'd1 << 64) - 128'd1, (128'd1 << 64) - 128'd1);
    finish_op("half_sq", (256'd1 << 128) - (256'd1 << 65) + 256'd1);
    release_out("half_sq");

    // Zero times negative yields plain zero.
    drive(128'd0, '0 - 128'd77);
    finish_op("zero_neg", 256'd0);
    release_out("zero_neg");

    // Backpressure with a queued operand pair.
    drive(128'd1000, 128'd1000);
    finish_op("bp", 256'd1000000);
    held = bus.product;
    @(negedge clk);
    bus.a = 128'd7;
    bus.b = '0 - 128'd9;
    bus.in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_hold_product", bus.product, held);
      check("bp_hold_flags", {254'd0, bus.out_valid, bus.in_ready}, 256'd2);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {254'd0, bus.out_valid, bus.in_ready}, 256'd1);
    bus.out_ready = 1'b0;
    finish_op("7x-9", '0 - 256'd63);
    release_out("7x-9");

    // Reset in the middle of an operation.
    drive(rand128(), rand128());
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {254'd0, bus.out_valid, bus.busy}, 256'd0);
    check("midrst_product", bus.product, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(128'd12, 128'd12);
    finish_op("12x12", 256'd144);
    release_out("12x12");

    // Randomized operands; the first keeps out_ready high throughout.
    for (int i = 0; i < 8; i++) begin
      ra = rand128();
      rb = rand128();
      if (i == 1) ra = ra >> $urandom_range(100, 0);
      if (i == 2) rb = '0 - (rb >> 70);
      if (i == 0) begin
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
      drive(ra, rb);
      finish_op("rand", ref_mul(ra, rb));
      release_out("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
